// File: rtl/trena_receptor_medida_if.sv
// Measurement bundle produced by the trena serial receiver: BCD digits,
// completion/error pulses and debug taps.
interface trena_receptor_medida_if;
    logic [3:0] centena;
    logic [3:0] dezena;
    logic [3:0] unidade;
    logic       medida_pronta;
    logic       erro;
    logic [6:0] db_dado;
    logic [3:0] db_estado;

    modport master (
        output centena, dezena, unidade, medida_pronta, erro, db_dado, db_estado
    );

    modport slave (
        input centena, dezena, unidade, medida_pronta, erro, db_dado, db_estado
    );
endinterface

// File: rtl/trena_receptor_medida.sv
// 7O1 serial receiver plus "DDD#" frame parser for the trena measurement link;
// presents the last valid measurement as three BCD digits.
module trena_receptor_medida #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            entrada_serial,
    trena_receptor_medida_if.master         medida
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] MEIO = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FIM  = CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] OCIOSO   = 3'd0;
    localparam logic [2:0] INICIO   = 3'd1;
    localparam logic [2:0] DADOS    = 3'd2;
    localparam logic [2:0] PARIDADE = 3'd3;
    localparam logic [2:0] PARADA   = 3'd4;

    localparam logic [1:0] ESPERA_C = 2'd0;
    localparam logic [1:0] ESPERA_D = 2'd1;
    localparam logic [1:0] ESPERA_U = 2'd2;
    localparam logic [1:0] ESPERA_H = 2'd3;

    logic          sinc1, rx, rx_ant;
    logic [2:0]    preparado;
    logic [2:0]    rx_estado;
    logic [CW-1:0] cnt;
    logic [2:0]    n_bit;
    logic [6:0]    dado_sr;
    logic          paridade;

    logic          fim, ruim, eh_digito, eh_hash;
    logic [6:0]    valor;

    logic [1:0]    estado;
    logic [3:0]    t_c, t_d, t_u;
    logic [3:0]    centena, dezena, unidade;
    logic          medida_pronta, erro;
    logic [6:0]    db_dado;

    // rx_ant only holds a real line value three edges after reset, so edge
    // detection stays disarmed until then (a line low at release is no start).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sinc1     <= 1'b1;
            rx        <= 1'b1;
            rx_ant    <= 1'b1;
            preparado <= '0;
            rx_estado <= OCIOSO;
            cnt       <= '0;
            n_bit     <= '0;
            dado_sr   <= '0;
            paridade  <= 1'b0;
        end else begin
            sinc1     <= entrada_serial;
            rx        <= sinc1;
            rx_ant    <= rx;
            preparado <= {preparado[1:0], 1'b1};
            case (rx_estado)
                OCIOSO: begin
                    cnt <= '0;
                    if (preparado[2] && rx_ant && !rx)
                        rx_estado <= INICIO;
                end
                INICIO: begin
                    if (cnt == MEIO) begin
                        cnt       <= '0;
                        n_bit     <= '0;
                        rx_estado <= rx ? OCIOSO : DADOS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DADOS: begin
                    if (cnt == FIM) begin
                        cnt     <= '0;
                        dado_sr <= {rx, dado_sr[6:1]};
                        if (n_bit == 3'd6)
                            rx_estado <= PARIDADE;
                        else
                            n_bit <= n_bit + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARIDADE: begin
                    if (cnt == FIM) begin
                        cnt       <= '0;
                        paridade  <= rx;
                        rx_estado <= PARADA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARADA: begin
                    if (cnt == FIM) begin
                        cnt       <= '0;
                        rx_estado <= OCIOSO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: rx_estado <= OCIOSO;
            endcase
        end
    end

    // Classification uses the stop sample live, so the parser acts on the same edge.
    always_comb begin
        fim       = (rx_estado == PARADA) && (cnt == FIM);
        ruim      = !rx || !(^{dado_sr, paridade});
        eh_digito = (dado_sr >= 7'h30) && (dado_sr <= 7'h39);
        eh_hash   = (dado_sr == 7'h23);
        valor     = dado_sr - 7'h30;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado        <= ESPERA_C;
            t_c           <= '0;
            t_d           <= '0;
            t_u           <= '0;
            centena       <= '0;
            dezena        <= '0;
            unidade       <= '0;
            medida_pronta <= 1'b0;
            erro          <= 1'b0;
            db_dado       <= '0;
        end else begin
            medida_pronta <= 1'b0;
            erro          <= 1'b0;
            if (fim) begin
                db_dado <= dado_sr;
                if (!ruim && eh_digito && estado != ESPERA_H) begin
                    if (estado == ESPERA_C)
                        t_c <= valor[3:0];
                    else if (estado == ESPERA_D)
                        t_d <= valor[3:0];
                    else
                        t_u <= valor[3:0];
                    estado <= estado + 2'd1;
                end else if (!ruim && eh_hash && estado == ESPERA_H) begin
                    centena       <= t_c;
                    dezena        <= t_d;
                    unidade       <= t_u;
                    medida_pronta <= 1'b1;
                    estado        <= ESPERA_C;
                end else begin
                    erro   <= 1'b1;
                    estado <= ESPERA_C;
                end
            end
        end
    end

    assign medida.centena       = centena;
    assign medida.dezena        = dezena;
    assign medida.unidade       = unidade;
    assign medida.medida_pronta = medida_pronta;
    assign medida.erro          = erro;
    assign medida.db_dado       = db_dado;
    assign medida.db_estado     = {2'b00, estado};
endmodule

// File: doc/trena_receptor_medida.md
# trena_receptor_medida

Serial receiver and frame decoder for the distance-meter measurement link. It sits at the far end of the trena's serial output: it deserialises 7O1 characters and parses the measurement frame (three ASCII digits followed by '#'). It then presents the hundreds, tens and units digits as BCD, together with a one-cycle completion pulse and an error pulse. Its outputs drive the same hexa7seg displays and debug pins used elsewhere in the design.

## Interface
- CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); must be ≥ 4.
- clock  in  1  single system clock; all flops on rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- entrada_serial  in  1  serial line, idle high, asynchronous to clock.
- centena  out  4  BCD hundreds digit of last valid frame.
- dezena  out  4  BCD tens digit of last valid frame.
- unidade  out  4  BCD units digit of last valid frame.
- medida_pronta  out  1  one-cycle pulse when centena/dezena/unidade update.
- erro  out  1  one-cycle pulse on a discarded character.
- db_dado  out  7  last received data byte, valid or not.
- db_estado  out  4  parser state code.

## Operation
- Line conditioning: 2-flop synchroniser on entrada_serial; all logic uses the synchronised value `rx`. The synchroniser resets to 1.
- Character format: start bit (0); 7 data bits, LSB first; odd parity (data ones + parity bit is odd); stop bit (1).
- Receiver FSM: OCIOSO → INICIO → DADOS → PARIDADE → PARADA → OCIOSO.
  - OCIOSO: a 1→0 transition of rx starts a character.
  - INICIO: rx is re-sampled at the mid-bit point. If rx = 1, the event is a glitch: return silently to OCIOSO with no erro pulse.
  - Each later bit is sampled once, at its mid-bit point.
- Character classification (after the stop sample):
  - Bad: stop = 0 (framing error) or parity mismatch.
  - Digit: 0x30–0x39; BCD value = byte − 0x30.
  - Hash: 0x23.
  - Other: any other good character.
- Parser FSM, with db_estado codes:
  - ESPERA_C (0): a digit stores temporary hundreds and moves to ESPERA_D.
  - ESPERA_D (1): a digit stores temporary tens and moves to ESPERA_U.
  - ESPERA_U (2): a digit stores temporary units and moves to ESPERA_H.
  - ESPERA_H (3): hash copies the temporaries to centena/dezena/unidade, pulses medida_pronta, and returns to ESPERA_C.
- Any unexpected character in any state pulses erro and returns to ESPERA_C, discarding the partial frame. Unexpected characters are: bad, other, a digit in ESPERA_H, or hash in ESPERA_C/D/U.
  - The character that caused the error is not reused as a new hundreds digit.
- centena/dezena/unidade change only on a complete valid frame and hold otherwise, including across error pulses.
- db_dado updates on every completed character, including bad ones.
- medida_pronta and erro are never asserted in the same cycle.

## Timing
- Reset values: centena = dezena = unidade = 0, medida_pronta = 0, erro = 0, db_dado = 0, db_estado = 0. Both FSMs are idle / ESPERA_C.
- Let t0 be the cycle in which rx is first seen at 0 in OCIOSO, H = CLKS_PER_BIT/2 (integer division) and N = CLKS_PER_BIT.
  - Start bit is checked at t0+H.
  - Data bit i (i = 0..6) is sampled at t0+H+(i+1)N.
  - Parity is sampled at t0+H+8N.
  - Stop is sampled at t0+H+9N.
- Classification registers at t0+H+9N+1.
  - db_dado, medida_pronta or erro, the new digit outputs and db_estado are all visible in that cycle.
- The receiver re-enters OCIOSO at t0+H+9N+1. It can detect the next start edge from that cycle on, so back-to-back characters are supported.
- Line-to-decision latency adds 2 cycles of synchroniser delay to every figure above.
- Reset asserted mid-character or mid-frame:
  - Everything returns to reset values immediately.
  - The partial character is dropped with no erro pulse.
  - After reset releases, a line that is currently low is not treated as a start bit until a 1→0 edge occurs.

## Test plan
Use CLKS_PER_BIT = 8 in simulation.
- Frame "123#" (0x31, 0x32, 0x33, 0x23 with parity bits 0, 0, 1, 0) → centena = 1, dezena = 2, unidade = 3; exactly one medida_pronta pulse, at stop+1 of '#'; erro stays 0; db_estado ends at 0.
- "123#" first, then "2" sent with parity flipped → erro pulse, db_estado = 0, outputs still 1/2/3. Then "045#" → outputs 0/4/5 and one medida_pronta pulse.
- Character '7' sent with stop bit = 0 → erro pulse, db_dado = 0x37, no output change.
- Line held low for 3 cycles (less than H) in idle → no erro, db_dado unchanged, receiver back in OCIOSO.
- Sequence "12A3#" → erro at 'A'. '3' becomes the hundreds digit (db_estado = 1), then '#' → erro. A following "999#" → 9/9/9 with one medida_pronta pulse.
- reset pulled low during the data bits of '#' in "456#" → all outputs 0 immediately. After release, a fresh "456#" → 4/5/6.
